// File: rtl/rect_fill_pkg.sv
// ---------------------------------------------------------------------------
// rect_fill_pkg
// Shared types and constants for the rectangle fill sequencer.
//   state_t   : sequencer states (IDLE, LOAD, FILL, DONE)
//   SCREEN_*  : default visible screen size, used when clipping is enabled
//   req_t     : fill request layout at the default coordinate/colour widths,
//               for producers (command decoder) that build requests
// ---------------------------------------------------------------------------
package rect_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SCREEN_W_DEFAULT = 160;
    localparam int SCREEN_H_DEFAULT = 120;

    localparam int REQ_COORD_W = 8;
    localparam int REQ_COLOR_W = 3;

    typedef struct packed {
        logic [REQ_COORD_W-1:0] x;
        logic [REQ_COORD_W-1:0] y;
        logic [REQ_COORD_W-1:0] w_m1;
        logic [REQ_COORD_W-1:0] h_m1;
        logic [REQ_COLOR_W-1:0] color;
    } req_t;

endpackage

// File: rtl/rect_fill_scan.sv
// ---------------------------------------------------------------------------
// rect_fill_scan
// Row-major offset iterator for the rectangle fill. dx runs 0..dx_max, then
// wraps to 0 while dy advances, up to dy_max. Counters are WIDTH bits and
// never need to go past their maximum, so a full 2^WIDTH square fits.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   clear          : zero both offsets (start of a new fill)
//   step           : advance by one pixel
//   dx_max, dy_max : inclusive iteration bounds
//   dx, dy         : current offsets
//   last           : current offset is the final pixel of the rectangle
// ---------------------------------------------------------------------------
module rect_fill_scan #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic [WIDTH-1:0] dx_max,
    input  logic [WIDTH-1:0] dy_max,
    output logic [WIDTH-1:0] dx,
    output logic [WIDTH-1:0] dy,
    output logic             last
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dx <= '0;
            dy <= '0;
        end else if (clear) begin
            dx <= '0;
            dy <= '0;
        end else if (step) begin
            if (dx < dx_max) begin
                dx <= dx + 1'b1;
            end else if (dy < dy_max) begin
                dx <= '0;
                dy <= dy + 1'b1;
            end
        end
    end

    assign last = (dx == dx_max) && (dy == dy_max);

endmodule

// File: rtl/rect_fill_ctrl.sv
// ---------------------------------------------------------------------------
// rect_fill_ctrl
// Fills an axis-aligned rectangle of one colour by emitting one pixel write
// per cycle on the plot port, in row-major order. Owns the plot port while
// busy and accepts one request at a time.
// Ports:
//   clock, reset           : clock, asynchronous active-high reset
//   req_valid / req_ready  : request handshake (ready only in IDLE)
//   req_x, req_y           : top-left corner
//   req_w_m1, req_h_m1     : width-1 / height-1
//   req_color              : fill colour
//   abort                  : end the current fill early (LOAD/FILL only)
//   plot_valid / plot_ready: pixel write handshake
//   plot_x, plot_y         : pixel coordinate (wraps mod 2^WIDTH)
//   plot_color             : pixel colour
//   busy                   : sequencer not idle
//   done                   : one-cycle pulse at the end of every fill
// Build option:
//   RECT_FILL_CLIP_EN      : clip fills to SCREEN_W x SCREEN_H; a fill whose
//                            corner lies off-screen emits no pixels.
// ---------------------------------------------------------------------------
module rect_fill_ctrl
    import rect_fill_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_x,
    input  logic [WIDTH-1:0]   req_y,
    input  logic [WIDTH-1:0]   req_w_m1,
    input  logic [WIDTH-1:0]   req_h_m1,
    input  logic [COLOR_W-1:0] req_color,
    input  logic               abort,
    output logic               plot_valid,
    input  logic               plot_ready,
    output logic [WIDTH-1:0]   plot_x,
    output logic [WIDTH-1:0]   plot_y,
    output logic [COLOR_W-1:0] plot_color,
    output logic               busy,
    output logic               done
);

`ifdef RECT_FILL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    // Screen extents and the constant one, sized to the WIDTH+1 bit domain
    // the clip arithmetic runs in.
    localparam logic [WIDTH:0] SCR_W   = (WIDTH+1)'(SCREEN_W);
    localparam logic [WIDTH:0] SCR_H   = (WIDTH+1)'(SCREEN_H);
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

    // Request captured at accept time, widths follow this instance.
    typedef struct packed {
        logic [WIDTH-1:0]   x;
        logic [WIDTH-1:0]   y;
        logic [WIDTH-1:0]   w_m1;
        logic [WIDTH-1:0]   h_m1;
        logic [COLOR_W-1:0] color;
    } fill_req_t;

    state_t           state;
    fill_req_t        req_reg;
    logic [WIDTH-1:0] dx_max_reg;
    logic [WIDTH-1:0] dy_max_reg;
    logic             plot_valid_reg;
    logic             done_reg;
    logic             req_ready_reg;

    logic [WIDTH-1:0] dx;
    logic [WIDTH-1:0] dy;
    logic             last;
    logic             scan_clear;
    logic             scan_step;

    // -----------------------------------------------------------------------
    // Iteration bounds, evaluated from the captured request while in LOAD.
    // Clipping works in WIDTH+1 bits so "room to the screen edge" cannot
    // wrap when compared against the requested extent.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   x_ext;
    logic [WIDTH:0]   y_ext;
    logic [WIDTH:0]   room_x;
    logic [WIDTH:0]   room_y;
    logic             off_screen;
    logic [WIDTH-1:0] clip_dx;
    logic [WIDTH-1:0] clip_dy;
    logic [WIDTH-1:0] bound_dx;
    logic [WIDTH-1:0] bound_dy;
    logic             empty;

    always_comb begin
        x_ext      = {1'b0, req_reg.x};
        y_ext      = {1'b0, req_reg.y};
        off_screen = (x_ext >= SCR_W) || (y_ext >= SCR_H);
        // Only meaningful when the corner is on-screen, where these cannot
        // underflow.
        room_x     = SCR_W - x_ext - ONE_EXT;
        room_y     = SCR_H - y_ext - ONE_EXT;
        clip_dx    = ({1'b0, req_reg.w_m1} <= room_x) ? req_reg.w_m1 : room_x[WIDTH-1:0];
        clip_dy    = ({1'b0, req_reg.h_m1} <= room_y) ? req_reg.h_m1 : room_y[WIDTH-1:0];

        bound_dx   = CLIP_EN ? clip_dx : req_reg.w_m1;
        bound_dy   = CLIP_EN ? clip_dy : req_reg.h_m1;
        empty      = CLIP_EN && off_screen;
    end

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            req_reg        <= '0;
            dx_max_reg     <= '0;
            dy_max_reg     <= '0;
            plot_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            req_ready_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        req_reg.x     <= req_x;
                        req_reg.y     <= req_y;
                        req_reg.w_m1  <= req_w_m1;
                        req_reg.h_m1  <= req_h_m1;
                        req_reg.color <= req_color;
                        req_ready_reg <= 1'b0;
                        state         <= LOAD;
                    end else begin
                        // Also raises ready on the first edge after reset.
                        req_ready_reg <= 1'b1;
                    end
                end

                LOAD: begin
                    dx_max_reg <= bound_dx;
                    dy_max_reg <= bound_dy;
                    if (abort || empty) begin
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end else begin
                        plot_valid_reg <= 1'b1;
                        state          <= FILL;
                    end
                end

                FILL: begin
                    // A pixel accepted alongside abort is still written; the
                    // sequencer simply stops after it.
                    if (abort || (plot_ready && last)) begin
                        plot_valid_reg <= 1'b0;
                        done_reg       <= 1'b1;
                        state          <= DONE;
                    end
                end

                DONE: begin
                    done_reg      <= 1'b0;
                    req_ready_reg <= 1'b1;
                    state         <= IDLE;
                end

                default: begin
                    plot_valid_reg <= 1'b0;
                    done_reg       <= 1'b0;
                    req_ready_reg  <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

    // Offsets restart every LOAD and advance on each accepted pixel that is
    // not the final one.
    assign scan_clear = (state == LOAD);
    assign scan_step  = (state == FILL) && plot_valid_reg && plot_ready && !last;

    rect_fill_scan #(
        .WIDTH (WIDTH)
    ) u_scan (
        .clock  (clock),
        .reset  (reset),
        .clear  (scan_clear),
        .step   (scan_step),
        .dx_max (dx_max_reg),
        .dy_max (dy_max_reg),
        .dx     (dx),
        .dy     (dy),
        .last   (last)
    );

    // Pixel coordinate is a pure function of registers, so it is stable
    // across stalls and goes to zero as soon as reset clears the request.
    assign plot_x     = req_reg.x + dx;
    assign plot_y     = req_reg.y + dy;
    assign plot_color = req_reg.color;
    assign plot_valid = plot_valid_reg;
    assign req_ready  = req_ready_reg;
    assign done       = done_reg;
    assign busy       = (state != IDLE);

endmodule
